// File: rtl/stream_chopper.sv
// Chops Width-element words into beats of cfg_chopsize_i elements, packing
// across word boundaries; partial tails leave on explicit or idle-timeout flush.
module stream_chopper #(
    parameter type element_t = logic [15:0],
    parameter int  Width     = 32
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              bypass_en_i,
    input  logic                              flush_i,
    input  logic                              cfg_auto_flush_en_i,
    input  logic [5:0]                        cfg_auto_flush_count_i,
    input  logic [$clog2(Width)-1:0]          cfg_chopsize_i,
    input  logic [Width*$bits(element_t)-1:0] data_i,
    input  logic                              valid_i,
    output logic                              ready_o,
    output logic [Width*$bits(element_t)-1:0] data_o,
    output logic [Width-1:0]                  valid_o,
    input  logic                              ready_i
);

    localparam int EW    = $bits(element_t);
    localparam int Depth = 2 * Width;
    localparam int CW    = $clog2(Depth + 1);
    localparam int AW    = $clog2(Depth);
    localparam int LW    = $clog2(Width);

    element_t       mem_q [Depth];
    element_t       mem_d [Depth];
    element_t       din   [Width];
    logic [CW-1:0]  cnt_q;
    logic [CW-1:0]  cnt_d;
    logic [CW-1:0]  tail_q;
    logic           fp_q;
    logic [5:0]     timer_q;

    logic           hs_in;
    logic           accept;
    logic           in_tail;
    logic           flush_set;
    logic           room;
    int             cnt_n;
    int             cs_n;
    int             beat_n;
    int             pop_n;
    int             base_n;
    logic [AW-1:0]  src;
    logic [LW-1:0]  lane;

    always_comb begin
        for (int i = 0; i < Width; i++) begin
            din[i] = data_i[i*EW +: EW];
        end
    end

    // A pending flush owns the output until its tail (captured length) drains
    always_comb begin
        cnt_n  = int'(cnt_q);
        cs_n   = (cfg_chopsize_i == '0) ? Width : int'(cfg_chopsize_i);
        beat_n = 0;
        if (fp_q) begin
            beat_n = int'(tail_q);
        end else if (cnt_n >= cs_n) begin
            beat_n = cs_n;
        end
        room      = (cnt_n <= Width);
        hs_in     = !bypass_en_i && valid_i && room;
        accept    = !bypass_en_i && ready_i && (beat_n != 0);
        pop_n     = accept ? beat_n : 0;
        in_tail   = (cnt_n > 0) && (cnt_n < cs_n);
        flush_set = in_tail && !fp_q &&
                    (flush_i || (cfg_auto_flush_en_i && !hs_in &&
                                 timer_q == cfg_auto_flush_count_i));
    end

    assign ready_o = bypass_en_i ? ready_i : room;

    always_comb begin
        data_o  = '0;
        valid_o = '0;
        if (bypass_en_i) begin
            data_o  = data_i;
            valid_o = {Width{valid_i}};
        end else begin
            for (int i = 0; i < Width; i++) begin
                if (i < beat_n) begin
                    valid_o[i]        = 1'b1;
                    data_o[i*EW +: EW] = mem_q[i];
                end
            end
        end
    end

    // Shift out the popped beat, then append the new word behind what remains
    always_comb begin
        base_n = cnt_n - pop_n;
        src    = '0;
        lane   = '0;
        for (int j = 0; j < Depth; j++) begin
            mem_d[j] = '0;
            if (j + pop_n < Depth) begin
                src      = AW'(j + pop_n);
                mem_d[j] = mem_q[src];
            end
            if (hs_in && j >= base_n && j < base_n + Width) begin
                lane     = LW'(j - base_n);
                mem_d[j] = din[lane];
            end
        end
        cnt_d = CW'(base_n + (hs_in ? Width : 0));
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            for (int j = 0; j < Depth; j++) begin
                mem_q[j] <= '0;
            end
            cnt_q   <= '0;
            tail_q  <= '0;
            fp_q    <= 1'b0;
            timer_q <= '0;
        end else if (!bypass_en_i) begin
            mem_q <= mem_d;
            cnt_q <= cnt_d;
            if (hs_in || cnt_n == 0 || accept) begin
                timer_q <= '0;
            end else if (in_tail && timer_q != 6'h3f) begin
                timer_q <= timer_q + 6'd1;
            end
            if (accept && fp_q) begin
                fp_q <= 1'b0;
            end else if (flush_set) begin
                fp_q   <= 1'b1;
                tail_q <= cnt_q;
            end
        end
    end

endmodule

// File: tb/tb_stream_chopper.sv
// Directed bench for stream_chopper: bypass, chop, flush, back-to-back
// ordering and mid-stream reset.
module tb_stream_chopper;

    localparam int W  = 32;
    localparam int EW = 16;
    localparam int DW = W * EW;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          bypass_en_i = 1'b0;
    logic          flush_i = 1'b0;
    logic          cfg_auto_flush_en_i = 1'b0;
    logic [5:0]    cfg_auto_flush_count_i = '0;
    logic [4:0]    cfg_chopsize_i = '0;
    logic [DW-1:0] data_i = '0;
    logic          valid_i = 1'b0;
    logic          ready_o;
    logic [DW-1:0] data_o;
    logic [W-1:0]  valid_o;
    logic          ready_i = 1'b1;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    stream_chopper dut (
        .clk                    (clk),
        .rstn                   (rstn),
        .bypass_en_i            (bypass_en_i),
        .flush_i                (flush_i),
        .cfg_auto_flush_en_i    (cfg_auto_flush_en_i),
        .cfg_auto_flush_count_i (cfg_auto_flush_count_i),
        .cfg_chopsize_i         (cfg_chopsize_i),
        .data_i                 (data_i),
        .valid_i                (valid_i),
        .ready_o                (ready_o),
        .data_o                 (data_o),
        .valid_o                (valid_o),
        .ready_i                (ready_i)
    );

    function automatic logic [DW-1:0] mkword(int base);
        logic [DW-1:0] w;
        w = '0;
        for (int i = 0; i < W; i++) w[i*EW +: EW] = 16'(base + i);
        return w;
    endfunction

    function automatic logic [DW-1:0] beat(int first, int n);
        logic [DW-1:0] w;
        w = '0;
        for (int i = 0; i < n; i++) w[i*EW +: EW] = 16'(first + i);
        return w;
    endfunction

    function automatic logic [W-1:0] mask(int n);
        logic [W-1:0] m;
        m = '0;
        for (int i = 0; i < n; i++) m[i] = 1'b1;
        return m;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) step();
        #1;
        total++;
        if (valid_o !== '0) begin
            bad++;
            $display("FAIL reset_valid: got %h want %h", valid_o, mask(0));
        end
        total++;
        if (data_o !== '0) begin
            bad++;
            $display("FAIL reset_data: got %h want 0", data_o);
        end
        total++;
        if (ready_o !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: got %b want 1", ready_o);
        end
        step();
        rstn = 1'b0;
    endtask

    task automatic test_bypass();
        logic [DW-1:0] w;
        logic          r;
        bypass_en_i    = 1'b1;
        cfg_chopsize_i = '0;
        valid_i        = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            step();
            w = '0;
            for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
            r = 1'($urandom_range(0, 1));
            data_i  = w;
            ready_i = r;
            #1;
            total++;
            if (data_o !== w || valid_o !== mask(W) || ready_o !== r) begin
                bad++;
                $display("FAIL bypass_%0d: got v=%h r=%b d=%h want v=%h r=%b d=%h",
                         k, valid_o, ready_o, data_o, mask(W), r, w);
            end
        end
        step();
        bypass_en_i = 1'b0;
        valid_i     = 1'b0;
        ready_i     = 1'b1;
        #1;
        total++;
        if (valid_o !== '0 || ready_o !== 1'b1) begin
            bad++;
            $display("FAIL bypass_state_held: got v=%h r=%b want v=0 r=1", valid_o, ready_o);
        end
    endtask

    task automatic test_chop8();
        cfg_chopsize_i = 5'd8;
        step();
        data_i  = mkword(0);
        valid_i = 1'b1;
        ready_i = 1'b1;
        #1;
        total++;
        if (valid_o !== '0) begin
            bad++;
            $display("FAIL chop8_latency: got %h want 0", valid_o);
        end
        for (int b = 0; b < 4; b++) begin
            step();
            valid_i = 1'b0;
            #1;
            total++;
            if (valid_o !== mask(8) || data_o !== beat(b * 8, 8)) begin
                bad++;
                $display("FAIL chop8_beat%0d: got v=%h d=%h want v=%h d=%h",
                         b, valid_o, data_o, mask(8), beat(b * 8, 8));
            end
        end
        step();
        #1;
        total++;
        if (valid_o !== '0) begin
            bad++;
            $display("FAIL chop8_empty: got %h want 0", valid_o);
        end
    endtask

    task automatic test_auto_flush();
        int n;
        cfg_chopsize_i         = 5'd5;
        cfg_auto_flush_en_i    = 1'b1;
        cfg_auto_flush_count_i = 6'd16;
        step();
        data_i  = mkword(100);
        valid_i = 1'b1;
        #1;
        for (int b = 0; b < 6; b++) begin
            step();
            valid_i = 1'b0;
            #1;
            total++;
            if (valid_o !== mask(5) || data_o !== beat(100 + b * 5, 5)) begin
                bad++;
                $display("FAIL af_beat%0d: got v=%h d=%h want v=%h d=%h",
                         b, valid_o, data_o, mask(5), beat(100 + b * 5, 5));
            end
        end
        step();
        #1;
        total++;
        if (valid_o !== '0) begin
            bad++;
            $display("FAIL af_tail_held: got %h want 0", valid_o);
        end
        n = 0;
        do begin
            step();
            #1;
            n++;
        end while (valid_o === '0 && n < 40);
        total++;
        if (n != 17) begin
            bad++;
            $display("FAIL af_delay: got %0d want %0d cycles", n, 17);
        end
        total++;
        if (valid_o !== mask(2) || data_o !== beat(130, 2)) begin
            bad++;
            $display("FAIL af_tail: got v=%h d=%h want v=%h d=%h",
                     valid_o, data_o, mask(2), beat(130, 2));
        end
        step();
        #1;
        total++;
        if (valid_o !== '0 || ready_o !== 1'b1) begin
            bad++;
            $display("FAIL af_drained: got v=%h r=%b want v=0 r=1", valid_o, ready_o);
        end
        cfg_auto_flush_en_i = 1'b0;
    endtask

    task automatic test_manual_flush();
        cfg_chopsize_i = 5'd5;
        step();
        data_i  = mkword(200);
        valid_i = 1'b1;
        #1;
        for (int b = 0; b < 6; b++) begin
            step();
            valid_i = 1'b0;
            #1;
            total++;
            if (valid_o !== mask(5) || data_o !== beat(200 + b * 5, 5)) begin
                bad++;
                $display("FAIL mf_beat%0d: got v=%h d=%h want v=%h d=%h",
                         b, valid_o, data_o, mask(5), beat(200 + b * 5, 5));
            end
        end
        repeat (6) step();
        #1;
        total++;
        if (valid_o !== '0) begin
            bad++;
            $display("FAIL mf_no_autoflush: got %h want 0", valid_o);
        end
        step();
        flush_i = 1'b1;
        #1;
        step();
        flush_i = 1'b0;
        #1;
        total++;
        if (valid_o !== mask(2) || data_o !== beat(230, 2)) begin
            bad++;
            $display("FAIL mf_tail: got v=%h d=%h want v=%h d=%h",
                     valid_o, data_o, mask(2), beat(230, 2));
        end
        step();
        #1;
        total++;
        if (valid_o !== '0) begin
            bad++;
            $display("FAIL mf_drained: got %h want 0", valid_o);
        end
    endtask

    task automatic test_back_to_back();
        int  sent;
        int  got;
        int  mcnt;
        int  cyc;
        int  n;
        bit  saw_full;
        cfg_chopsize_i         = 5'd7;
        cfg_auto_flush_en_i    = 1'b1;
        cfg_auto_flush_count_i = 6'd3;
        sent = 0; got = 0; mcnt = 0; cyc = 0; saw_full = 0;
        while (got < 320 && cyc < 3000) begin
            step();
            cyc++;
            ready_i = 1'($urandom_range(0, 1));
            valid_i = (sent < 10);
            data_i  = mkword(1000 + 32 * sent);
            #1;
            total++;
            if (ready_o !== (mcnt <= 32)) begin
                bad++;
                $display("FAIL b2b_ready: got %b want %b (cnt %0d)", ready_o, mcnt <= 32, mcnt);
            end
            if (!ready_o) saw_full = 1;
            n = (mcnt >= 7) ? 7 : mcnt;
            total++;
            if (mcnt >= 7 ? (valid_o !== mask(7))
                          : (valid_o !== '0 && valid_o !== mask(mcnt))) begin
                bad++;
                $display("FAIL b2b_valid: got %h want %h", valid_o, mask(n));
            end
            if (ready_i && valid_o !== '0) begin
                for (int i = 0; i < n; i++) begin
                    total++;
                    if (data_o[i*EW +: EW] !== 16'(1000 + got)) begin
                        bad++;
                        $display("FAIL b2b_elem%0d: got %h want %h",
                                 got, data_o[i*EW +: EW], 16'(1000 + got));
                    end
                    got++;
                end
                mcnt -= n;
            end
            if (valid_i && ready_o) begin
                sent++;
                mcnt += 32;
            end
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        total++;
        if (got != 320) begin
            bad++;
            $display("FAIL b2b_count: got %0d want %0d elements", got, 320);
        end
        total++;
        if (!saw_full) begin
            bad++;
            $display("FAIL b2b_backpressure: got ready_o never low want low once");
        end
        step();
        #1;
        total++;
        if (valid_o !== '0) begin
            bad++;
            $display("FAIL b2b_drained: got %h want 0", valid_o);
        end
        cfg_auto_flush_en_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        cfg_chopsize_i = 5'd5;
        step();
        data_i  = mkword(300);
        valid_i = 1'b1;
        ready_i = 1'b1;
        #1;
        step();
        valid_i = 1'b0;
        repeat (4) step();
        ready_i = 1'b0;
        #1;
        total++;
        if (valid_o !== mask(5) || data_o !== beat(320, 5)) begin
            bad++;
            $display("FAIL rm_cnt12: got v=%h d=%h want v=%h d=%h",
                     valid_o, data_o, mask(5), beat(320, 5));
        end
        rstn = 1'b1;
        #1;
        total++;
        if (valid_o !== '0 || ready_o !== 1'b1 || data_o !== '0) begin
            bad++;
            $display("FAIL rm_async: got v=%h r=%b want v=0 r=1", valid_o, ready_o);
        end
        step();
        rstn = 1'b0;
        step();
        data_i  = mkword(600);
        valid_i = 1'b1;
        ready_i = 1'b1;
        #1;
        step();
        valid_i = 1'b0;
        #1;
        total++;
        if (valid_o !== mask(5) || data_o !== beat(600, 5)) begin
            bad++;
            $display("FAIL rm_first_beat: got v=%h d=%h want v=%h d=%h",
                     valid_o, data_o, mask(5), beat(600, 5));
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_chop8();
        test_auto_flush();
        test_manual_flush();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
